// File: rtl/systolic_feeder.sv
// systolic_feeder
//   Loads one N x N weight tile, shifts it down the array's north edge, issues
//   the per-row weight-switch wave, then streams activation vectors into the
//   west edge with a one-cycle-per-row skew. Data passes through bit-exact.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   start                       one-cycle job request (honoured in IDLE only)
//   w_valid/w_ready, w_data     weight-row handshake, column c in [c*DW +: DW]
//   x_valid/x_ready, x_data     activation handshake, row r in [r*DW +: DW]
//   x_last                      final vector of the job
//   north_weight/north_accept_w weight per column and accept strobe (SHIFT only)
//   west_input/west_valid       skewed activation per row
//   west_switch                 skewed per-row weight-switch pulse
//   busy, done                  job active / one-cycle completion pulse
//
// Build option
//   FEEDER_ZERO_GATE_EN  defined: west_input[r] reads 0 whenever west_valid[r]=0.
//                        undefined: west_input[r] holds its last valid value.
//
// state    | meaning
// IDLE     | waiting for start
// COLLECT  | accepting N weight rows into the buffer
// SHIFT    | N cycles pushing buffered rows out, last row first
// SWITCH   | one cycle; launches the weight-switch wave
// STREAM   | accepting activation vectors until x_last
// DRAIN    | letting the final vector reach the last row

module systolic_feeder #(
  parameter int N  = 2,
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            w_valid,
  output logic            w_ready,
  input  logic [N*DW-1:0] w_data,
  input  logic            x_valid,
  output logic            x_ready,
  input  logic [N*DW-1:0] x_data,
  input  logic            x_last,
  output logic [N*DW-1:0] north_weight,
  output logic [N-1:0]    north_accept_w,
  output logic [N*DW-1:0] west_input,
  output logic [N-1:0]    west_valid,
  output logic [N-1:0]    west_switch,
  output logic            busy,
  output logic            done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] NM1 = CW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_SHIFT   = 3'd2,
    S_SWITCH  = 3'd3,
    S_STREAM  = 3'd4,
    S_DRAIN   = 3'd5
  } state_t;

  state_t                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        done_q, done_d;
  logic [N-1:0][N*DW-1:0]      wbuf_q, wbuf_d;
  logic [N-1:0]                vld_q, vld_d;
  logic [N-1:0][N*DW-1:0]      dpipe_q, dpipe_d;
  logic [N-1:0]                sw_q, sw_d;
  logic                        w_hs, x_hs;

  assign w_hs = (state_q == S_COLLECT) && w_valid;
  assign x_hs = (state_q == S_STREAM) && x_valid;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      wbuf_q  <= '0;
      vld_q   <= '0;
      dpipe_q <= '0;
      sw_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      wbuf_q  <= wbuf_d;
      vld_q   <= vld_d;
      dpipe_q <= dpipe_d;
      sw_q    <= sw_d;
    end
  end

  // Next state; cnt_q is a shared down-counter reloaded on each phase entry
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_COLLECT;
          cnt_d   = NM1;
        end
      end
      S_COLLECT: begin
        if (w_valid) begin
          if (cnt_q == '0) begin
            state_d = S_SHIFT;
            cnt_d   = NM1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      S_SHIFT: begin
        if (cnt_q == '0) state_d = S_SWITCH;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_SWITCH: state_d = S_STREAM;
      S_STREAM: begin
        if (x_hs && x_last) begin
          state_d = S_DRAIN;
          cnt_d   = NM1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Buffer and skew pipelines. Each data stage only loads when a valid vector
  // passes, so stage r always holds the most recent vector seen by row r.
  always_comb begin
    wbuf_d = wbuf_q;
    if (w_hs) wbuf_d[NM1 - cnt_q] = w_data;

    vld_d      = '0;
    dpipe_d    = dpipe_q;
    sw_d       = '0;
    vld_d[0]   = x_hs;
    sw_d[0]    = (state_q == S_SWITCH);
    if (x_hs) dpipe_d[0] = x_data;
    for (int k = 1; k < N; k++) begin
      vld_d[k] = vld_q[k-1];
      sw_d[k]  = sw_q[k-1];
      if (vld_q[k-1]) dpipe_d[k] = dpipe_q[k-1];
    end
  end

  // Outputs
  always_comb begin
    w_ready        = (state_q == S_COLLECT);
    x_ready        = (state_q == S_STREAM);
    busy           = (state_q != S_IDLE);
    done           = done_q;
    north_accept_w = '0;
    north_weight   = '0;
    // Counter runs N-1..0 across SHIFT, so slot N-1 goes out first
    if (state_q == S_SHIFT) begin
      north_accept_w = '1;
      north_weight   = wbuf_q[cnt_q];
    end
    west_valid  = vld_q;
    west_switch = sw_q;
    west_input  = '0;
    for (int r = 0; r < N; r++) begin
`ifdef FEEDER_ZERO_GATE_EN
      west_input[r*DW +: DW] = vld_q[r] ? dpipe_q[r][r*DW +: DW] : '0;
`else
      west_input[r*DW +: DW] = dpipe_q[r][r*DW +: DW];
`endif
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
module tb_systolic_feeder;
  localparam int N    = 2;
  localparam int DW   = 16;
  localparam int W    = N * DW;
  localparam int MAXC = 4096;

  logic          clk = 1'b0;
  logic          rst, start, w_valid, x_valid, x_last;
  logic [W-1:0]  w_data, x_data;
  logic          w_ready, x_ready, busy, done;
  logic [W-1:0]  north_weight, west_input;
  logic [N-1:0]  north_accept_w, west_valid, west_switch;

  systolic_feeder #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .start(start),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data), .x_last(x_last),
    .north_weight(north_weight), .north_accept_w(north_accept_w),
    .west_input(west_input), .west_valid(west_valid), .west_switch(west_switch),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Expected outputs per absolute cycle, filled in by the job model
  bit           e_wr[MAXC], e_xr[MAXC], e_busy[MAXC], e_done[MAXC];
  logic [N-1:0] e_acc[MAXC], e_wv[MAXC], e_sw[MAXC];
  logic [W-1:0] e_nw[MAXC];
  logic [DW-1:0] e_wd[MAXC][N];
  logic [DW-1:0] held[N];
  int done_cyc = -1;
  int last_s = 0;

  logic [W-1:0] wrows[2];
  logic [W-1:0] xvec[2];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  initial begin
    for (int c = 0; c < MAXC; c++) begin
      e_wr[c] = 0; e_xr[c] = 0; e_busy[c] = 0; e_done[c] = 0;
      e_acc[c] = '0; e_wv[c] = '0; e_sw[c] = '0; e_nw[c] = '0;
      for (int r = 0; r < N; r++) e_wd[c][r] = '0;
    end
    for (int r = 0; r < N; r++) held[r] = '0;
  end

  // Single compare process: every cycle, mid-cycle
  always @(negedge clk) begin
    if (cyc < MAXC) begin
      if (rst) for (int r = 0; r < N; r++) held[r] = '0;
      check("w_ready", W'(w_ready), W'(e_wr[cyc]));
      check("x_ready", W'(x_ready), W'(e_xr[cyc]));
      check("busy", W'(busy), W'(e_busy[cyc]));
      check("done", W'(done), W'(e_done[cyc]));
      check("north_accept_w", W'(north_accept_w), W'(e_acc[cyc]));
      check("north_weight", north_weight, e_nw[cyc]);
      check("west_valid", W'(west_valid), W'(e_wv[cyc]));
      check("west_switch", W'(west_switch), W'(e_sw[cyc]));
      for (int r = 0; r < N; r++) begin
        logic [DW-1:0] ex;
        if (e_wv[cyc][r]) held[r] = e_wd[cyc][r];
`ifdef FEEDER_ZERO_GATE_EN
        ex = e_wv[cyc][r] ? held[r] : '0;
`else
        ex = held[r];
`endif
        check("west_input_row", W'(west_input[r*DW +: DW]), W'(ex));
      end
      if (done) done_cyc = cyc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic junk();
    start   = 1'b0;
    w_valid = 1'($urandom_range(0, 1));
    w_data  = $urandom;
    x_valid = 1'($urandom_range(0, 1));
    x_data  = $urandom;
    x_last  = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int c = cyc; c < MAXC; c++) begin
      e_wr[c] = 0; e_xr[c] = 0; e_busy[c] = 0; e_done[c] = 0;
      e_acc[c] = '0; e_wv[c] = '0; e_sw[c] = '0; e_nw[c] = '0;
    end
    #1;
    check("rst_busy", W'(busy), '0);
    check("rst_x_ready", W'(x_ready), '0);
    check("rst_west_valid", W'(west_valid), '0);
    check("rst_west_input", west_input, '0);
    check("rst_west_switch", W'(west_switch), '0);
    tick();
    rst = 1'b0;
    junk();
  endtask

  // wgap/xgap: -1 random, else fixed gap; dw: use directed data tables;
  // abort_at: >0 asserts reset that many cycles into STREAM; spam: stray starts
  task automatic run_job(input int wgap, input int nvec, input int xgap,
                         input bit dw, input int abort_at, input bit spam);
    logic [W-1:0] slot[N];
    int hs, g, h, s, sent, l, n;
    bit wv, xv, lst;
    tick();
    junk();
    start = 1'b1;
    tick();
    hs = 0; g = 1000; n = 0;
    forever begin
      junk();
      start = spam ? 1'($urandom_range(0, 2) == 0) : 1'b0;
      e_wr[cyc] = 1; e_busy[cyc] = 1;
      if (wgap >= 0) wv = (g >= wgap);
      else           wv = ($urandom_range(0, 2) != 0) || (g > 6);
      w_valid = wv;
      if (dw) w_data = wrows[hs];
      if (wv) begin
        slot[hs] = w_data; hs++; g = 0;
      end else g++;
      if (hs == N) break;
      tick();
    end
    h = cyc;
    for (int j = 0; j < N; j++) begin
      e_busy[h+1+j] = 1;
      e_acc[h+1+j]  = '1;
      e_nw[h+1+j]   = slot[N-1-j];
    end
    e_busy[h+N+1] = 1;
    s = h + N + 2;
    last_s = s;
    for (int r = 0; r < N; r++) e_sw[s+r][r] = 1'b1;
    if (dw && wgap == 0) begin
      check("pin_shift0", e_nw[h+1], 32'h0400_0300);
      check("pin_shift1", e_nw[h+2], 32'h0200_0100);
    end
    while (cyc < s - 1) begin
      tick();
      junk();
      start = spam ? 1'($urandom_range(0, 2) == 0) : 1'b0;
    end
    tick();
    sent = 0; g = (xgap >= 0) ? xgap : 0;
    forever begin
      junk();
      start = spam ? 1'($urandom_range(0, 2) == 0) : 1'b0;
      e_xr[cyc] = 1; e_busy[cyc] = 1;
      if (abort_at > 0 && cyc - s == abort_at) begin
        do_reset();
        return;
      end
      if (xgap >= 0) xv = (g >= xgap);
      else           xv = ($urandom_range(0, 2) != 0) || (g > 6);
      x_valid = xv;
      if (dw) x_data = xvec[sent];
      lst = xv && (sent == nvec - 1);
      if (xv) x_last = lst;
      if (xv) begin
        for (int r = 0; r < N; r++) begin
          e_wv[cyc+1+r][r] = 1'b1;
          e_wd[cyc+1+r][r] = x_data[r*DW +: DW];
        end
        sent++; g = 0;
      end else g++;
      if (lst) break;
      tick();
    end
    l = cyc;
    for (int c = l + 1; c <= l + N; c++) e_busy[c] = 1;
    e_done[l+N+1] = 1;
    while (cyc < l + N + 3) begin
      tick();
      junk();
      if (cyc < l + N + 1) start = spam ? 1'($urandom_range(0, 2) == 0) : 1'b0;
    end
  endtask

  initial begin
    wrows[0] = 32'h0200_0100;
    wrows[1] = 32'h0400_0300;
    xvec[0]  = 32'h0080_0100;
    xvec[1]  = 32'h0040_0200;
    rst = 1'b1;
    start = 0; w_valid = 0; x_valid = 0; x_last = 0; w_data = '0; x_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (5) begin tick(); junk(); end

    // Directed tile and two-vector stream; done lands four cycles after t=S
    run_job(0, 2, 0, 1'b1, 0, 1'b0);
    check("done_at_t_plus_4", W'(done_cyc), W'(last_s + 4));
    // Stalled weight load
    run_job(3, 2, 0, 1'b1, 0, 1'b0);
    // One-cycle bubble between vectors
    run_job(0, 3, 1, 1'b0, 0, 1'b0);
    // Reset mid-STREAM, then clean jobs
    run_job(-1, 6, -1, 1'b0, 3, 1'b0);
    repeat (4) begin tick(); junk(); end
    run_job(-1, 4, -1, 1'b0, 0, 1'b1);
    for (int i = 0; i < 12; i++)
      run_job(-1, $urandom_range(1, 6), -1, 1'b0, 0, 1'($urandom_range(0, 1)));
    repeat (3) begin tick(); junk(); end
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
